// File: rtl/mux2x1.sv
// 2:1 data selector with an optional output register and a "data captured since reset" flag.
// With REG_OUT=0 the register is bypassed and y_valid simply mirrors the reset level.
module mux2x1 #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
);

  logic [WIDTH-1:0] sel_data;

  always_comb begin
    sel_data = sel ? b : a;
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] y_q;
    logic             valid_q;

    // Reset takes priority over en; en=0 freezes both data and flag.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        y_q     <= '0;
        valid_q <= 1'b0;
      end else if (en) begin
        y_q     <= sel_data;
        valid_q <= 1'b1;
      end
    end

    always_comb begin
      y       = y_q;
      y_valid = valid_q;
    end
  end else begin : g_byp
    // clk and en have no effect in bypass mode.
    logic unused_clk_en;

    always_comb begin
      y             = sel_data;
      y_valid       = rst_n;
      unused_clk_en = clk ^ en;
    end
  end

endmodule

// File: tb/tb_mux2x1.sv
// Scoreboard bench for mux2x1: narrow registered, wide registered and bypass instances.
// Stimulus pushes expected outputs tagged with the cycle they are due; a monitor pops and checks.
module tb_mux2x1;

  typedef struct {
    int unsigned dut;
    logic [7:0]  y;
    logic        v;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  logic        clk;
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  logic        bp_strobe = 1'b0;

  // Narrow registered instance
  logic       n_rst_n, n_en, n_a, n_b, n_sel, n_y, n_v;
  // Wide registered instance
  logic       w_rst_n, w_en, w_sel, w_v;
  logic [7:0] w_a, w_b, w_y;
  // Bypass instance (no clock)
  logic       bp_rst_n, bp_en, bp_a, bp_b, bp_sel, bp_y, bp_v;

  mux2x1 #(.WIDTH(1), .REG_OUT(1'b1)) u_narrow (
    .clk(clk), .rst_n(n_rst_n), .en(n_en), .a(n_a), .b(n_b), .sel(n_sel),
    .y(n_y), .y_valid(n_v)
  );

  mux2x1 #(.WIDTH(8), .REG_OUT(1'b1)) u_wide (
    .clk(clk), .rst_n(w_rst_n), .en(w_en), .a(w_a), .b(w_b), .sel(w_sel),
    .y(w_y), .y_valid(w_v)
  );

  mux2x1 #(.WIDTH(1), .REG_OUT(1'b0)) u_byp (
    .clk(1'b0), .rst_n(bp_rst_n), .en(bp_en), .a(bp_a), .b(bp_b), .sel(bp_sel),
    .y(bp_y), .y_valid(bp_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // now=1: check against current outputs; now=0: check after the next rising edge.
  task automatic push_exp(input int unsigned dut, input logic [7:0] y, input logic v,
                          input string name, input bit now);
    exp_t e;
    e.dut  = dut;
    e.y    = y;
    e.v    = v;
    e.due  = now ? cyc : cyc + 1;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_one(input exp_t e);
    logic [7:0] act_y;
    logic       act_v;
    case (e.dut)
      0:       begin act_y = {7'b0, n_y};  act_v = n_v;  end
      1:       begin act_y = w_y;          act_v = w_v;  end
      default: begin act_y = {7'b0, bp_y}; act_v = bp_v; end
    endcase
    n_tests++;
    if (act_y !== e.y || act_v !== e.v) begin
      n_fail++;
      $display("FAIL %s: got y=%h y_valid=%b, expected y=%h y_valid=%b",
               e.name, act_y, act_v, e.y, e.v);
    end
  endtask

  // Monitor: wakes on each falling edge (registered outputs) or on a bypass strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or bp_strobe);
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check_one(e);
      end
    end
  end

  initial begin
    n_rst_n = 1'b0; n_en = 1'b1; n_a = 1'b1; n_b = 1'b1; n_sel = 1'b0;
    w_rst_n = 1'b0; w_en = 1'b1; w_a = 8'hA5; w_b = 8'h3C; w_sel = 1'b0;
    bp_rst_n = 1'b0; bp_en = 1'b0; bp_a = 1'b0; bp_b = 1'b1; bp_sel = 1'b1;

    // Reset held for 2 cycles with en=1, a=b=1: reset wins.
    push_exp(0, 8'h00, 1'b0, "rst_cycle0", 1'b0);
    push_exp(1, 8'h00, 1'b0, "wide_rst", 1'b0);
    tick();
    push_exp(0, 8'h00, 1'b0, "rst_cycle1", 1'b0);
    tick();
    n_rst_n = 1'b1;
    push_exp(0, 8'h01, 1'b1, "rst_release", 1'b0);
    tick();

    // Truth table
    n_sel = 1'b0; n_a = 1'b0; n_b = 1'b1; push_exp(0, 8'h00, 1'b1, "tt_s0_a0_b1", 1'b0); tick();
    n_sel = 1'b1; n_a = 1'b0; n_b = 1'b1; push_exp(0, 8'h01, 1'b1, "tt_s1_a0_b1", 1'b0); tick();
    n_sel = 1'b0; n_a = 1'b1; n_b = 1'b0; push_exp(0, 8'h01, 1'b1, "tt_s0_a1_b0", 1'b0); tick();
    n_sel = 1'b1; n_a = 1'b1; n_b = 1'b0; push_exp(0, 8'h00, 1'b1, "tt_s1_a1_b0", 1'b0); tick();

    // Hold with en=0
    n_sel = 1'b1; n_b = 1'b1; push_exp(0, 8'h01, 1'b1, "hold_load", 1'b0); tick();
    n_en = 1'b0; n_sel = 1'b0; n_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_exp(0, 8'h01, 1'b1, "hold_en0", 1'b0);
      tick();
    end
    n_en = 1'b1; push_exp(0, 8'h00, 1'b1, "hold_release", 1'b0); tick();

    // Wide path, sel toggling every cycle
    w_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_sel = i[0];
      push_exp(1, w_sel ? 8'h3C : 8'hA5, 1'b1, "wide_toggle", 1'b0);
      tick();
    end

    // Reset mid-operation, then an idle edge, then fresh data
    w_rst_n = 1'b0; push_exp(1, 8'h00, 1'b0, "mid_rst", 1'b0); tick();
    w_rst_n = 1'b1; w_en = 1'b0; w_sel = 1'b0; w_a = 8'h11;
    push_exp(1, 8'h00, 1'b0, "post_rst_en0", 1'b0); tick();
    w_en = 1'b1; push_exp(1, 8'h11, 1'b1, "post_rst_load", 1'b0); tick();
    tick();
    tick();

    // Bypass: vectors every 10 ns, checked in the same time step
    #1;
    push_exp(2, 8'h01, 1'b0, "byp_rst_valid", 1'b1); bp_strobe = ~bp_strobe; #9;
    bp_rst_n = 1'b1;
    bp_sel = 1'b0; bp_a = 1'b0; bp_b = 1'b1; bp_en = 1'b1; #1;
    push_exp(2, 8'h00, 1'b1, "byp_s0_a0_b1", 1'b1); bp_strobe = ~bp_strobe; #9;
    bp_sel = 1'b1; bp_a = 1'b0; bp_b = 1'b1; bp_en = 1'b0; #1;
    push_exp(2, 8'h01, 1'b1, "byp_s1_a0_b1", 1'b1); bp_strobe = ~bp_strobe; #9;
    bp_sel = 1'b0; bp_a = 1'b1; bp_b = 1'b0; #1;
    push_exp(2, 8'h01, 1'b1, "byp_s0_a1_b0", 1'b1); bp_strobe = ~bp_strobe; #9;
    bp_sel = 1'b1; bp_a = 1'b1; bp_b = 1'b0; #1;
    push_exp(2, 8'h00, 1'b1, "byp_s1_a1_b0", 1'b1); bp_strobe = ~bp_strobe; #9;

    // Drain with a bounded wait
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: never checked, expected y=%h y_valid=%b", e.name, e.y, e.v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
